// File: rtl/common.sv
// Shared cbus protocol types used by the caches, the arbiter and the memory controller.
package common;

  typedef enum logic [2:0] {
    LEN1  = 3'd0,
    LEN2  = 3'd1,
    LEN4  = 3'd2,
    LEN8  = 3'd3,
    LEN16 = 3'd4
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    cbus_len_t   len;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arb_select.sv
// Combinational picker: first valid requester found when searching upward from last_index+1, modulo NUM_REQ.
// Fixed priority is this same search with last_index tied to NUM_REQ-1.
module cbus_arb_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_index,
  output logic [IDX_W-1:0]   index,
  output logic               any_valid
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written in always_comb gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    index     = '0;
    any_valid = 1'b0;
    cand      = '0;
    // Walk from furthest to nearest so the candidate right after last_index wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_index) + k) % NUM_REQ);
      if (valid[cand]) begin
        index     = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Grants the memory cbus to one cache for a whole transaction and steers the response back.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest-numbered port wins.
module cbus_arbiter
  import common::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic       clk,
  input  logic       reset_,
  input  cbus_req_t  ireqs  [NUM_REQ],
  output cbus_resp_t oresps [NUM_REQ],
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state, state_nxt;
  idx_t               index, index_nxt;
  idx_t               last_index;
  idx_t               sel_index;
  logic               any_valid;
  logic [NUM_REQ-1:0] valid_vec;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_valid
    assign valid_vec[i] = ireqs[i].valid;
  end

  cbus_arb_select #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_select (
    .valid     (valid_vec),
    .last_index(last_index),
    .index     (sel_index),
    .any_valid (any_valid)
  );

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  idx_t last_index_nxt;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) last_index <= idx_t'(NUM_REQ - 1);
    else         last_index <= last_index_nxt;
  end
`else
  assign last_index = idx_t'(NUM_REQ - 1);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= ST_IDLE;
      index <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    last_index_nxt = last_index;
`endif
    unique case (state)
      ST_IDLE: begin
        if (any_valid) begin
          state_nxt = ST_BUSY;
          index_nxt = sel_index;
        end
      end
      ST_BUSY: begin
        // The final beat ends the grant; the following cycle is always a bus bubble.
        if (cresp.ready && cresp.last) begin
          state_nxt = ST_IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
          last_index_nxt = index;
`endif
        end
      end
    endcase
  end

  always_comb begin
    creq = '0;
    for (int i = 0; i < NUM_REQ; i++) oresps[i] = '0;
    if (state == ST_BUSY) begin
      creq          = ireqs[index];
      oresps[index] = cresp;
    end
  end

  // The arbiter has no recovery path if the granted cache abandons its transaction.
  a_hold_valid: assert property (@(posedge clk) disable iff (!reset_)
    (state == ST_BUSY) |-> ireqs[index].valid)
    else $error("cbus_arbiter: granted requester dropped valid mid-transaction");

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: grant latency, bursts, contention, reset mid-burst and stalls.
module tb_cbus_arbiter;
  import common::*;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  cbus_req_t  ireqs  [2];
  cbus_resp_t oresps [2];
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(2)) dut (
    .clk   (clk),
    .reset_(reset_),
    .ireqs (ireqs),
    .oresps(oresps),
    .creq  (creq),
    .cresp (cresp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input cbus_len_t l);
    ireqs[p].valid = v;
    ireqs[p].write = 1'b0;
    ireqs[p].addr  = a;
    ireqs[p].len   = l;
    ireqs[p].data  = a ^ 32'h5A5A_5A5A;
  endtask

  task automatic set_resp(input logic r, input logic l, input logic [31:0] d);
    cresp.ready = r;
    cresp.last  = l;
    cresp.data  = d;
  endtask

  function automatic logic [31:0] granted_port();
    return (creq.addr[15:12] == 4'h5) ? 32'd1 : 32'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(0, 1'b0, 32'h0, LEN1);
    set_req(1, 1'b0, 32'h0, LEN1);
    set_resp(1'b0, 1'b0, 32'h0);
    #12;
    check("rst_creq_valid", 32'(creq.valid), 32'd0);
    check("rst_oresp0_zero", 32'(oresps[0] != '0), 32'd0);
    check("rst_oresp1_zero", 32'(oresps[1] != '0), 32'd0);
    #1 reset_ = 1'b1;
    tick();

    // Single-beat read from port 1
    set_req(1, 1'b1, 32'h8000_0010, LEN1);
    #1 check("t1_c0_no_grant", 32'(creq.valid), 32'd0);
    tick();
    #1 check("t1_c1_valid", 32'(creq.valid), 32'd1);
    check("t1_c1_addr", creq.addr, 32'h8000_0010);
    check("t1_c1_len", 32'(creq.len), 32'(LEN1));
    tick();
    tick();
    set_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    #1 check("t1_c3_data", oresps[1].data, 32'hDEAD_BEEF);
    check("t1_c3_last", 32'(oresps[1].last), 32'd1);
    check("t1_c3_oresp0_zero", 32'(oresps[0] != '0), 32'd0);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h8000_0010, LEN1);
    #1 check("t1_c4_released", 32'(creq.valid), 32'd0);

    // Contention: port 0 first (fixed priority, and round-robin after port 1 was last)
    tick();
    set_req(0, 1'b1, 32'h0000_2000, LEN1);
    set_req(1, 1'b1, 32'h0000_3000, LEN1);
    #1 check("t3_c0_no_grant", 32'(creq.valid), 32'd0);
    tick();
    #1 check("t3_c1_addr_p0", creq.addr, 32'h0000_2000);
    set_resp(1'b1, 1'b1, 32'h1111_0000);
    #1 check("t3_c1_p0_last", 32'(oresps[0].last), 32'd1);
    check("t3_c1_p1_held", 32'(oresps[1] != '0), 32'd0);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(0, 1'b0, 32'h0000_2000, LEN1);
    #1 check("t3_c2_bubble", 32'(creq.valid), 32'd0);
    tick();
    #1 check("t3_c3_p1_valid", 32'(creq.valid), 32'd1);
    check("t3_c3_addr_p1", creq.addr, 32'h0000_3000);
    set_resp(1'b1, 1'b1, 32'h2222_0000);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0000_3000, LEN1);
    #1 check("t3_c4_idle", 32'(creq.valid), 32'd0);

    // Both ports request continuously for four transactions
    set_req(0, 1'b1, 32'h0000_4000, LEN1);
    set_req(1, 1'b1, 32'h0000_5000, LEN1);
    for (int t = 0; t < 4; t++) begin
      tick();
      #1 check("t4_valid", 32'(creq.valid), 32'd1);
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      check("t4_order", granted_port(), 32'(t % 2));
`else
      check("t4_order", granted_port(), 32'd0);
`endif
      set_resp(1'b1, 1'b1, 32'(t));
      tick();
      set_resp(1'b0, 1'b0, 32'h0);
      if (t == 3) begin
        set_req(0, 1'b0, 32'h0000_4000, LEN1);
        set_req(1, 1'b0, 32'h0000_5000, LEN1);
      end
      #1 check("t4_bubble", 32'(creq.valid), 32'd0);
    end

    // 16-beat burst on port 0
    tick();
    set_req(0, 1'b1, 32'h0000_1000, LEN16);
    tick();
    for (int b = 0; b < 16; b++) begin
      set_resp(1'b1, b == 15, 32'h100 + 32'(b));
      #1 check("t2_beat_data", oresps[0].data, 32'h100 + 32'(b));
      check("t2_beat_p1_zero", 32'(oresps[1] != '0), 32'd0);
      if (b == 15) check("t2_last_beat", 32'(oresps[0].last), 32'd1);
      tick();
    end
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(0, 1'b0, 32'h0000_1000, LEN16);
    #1 check("t2_busy_cleared", 32'(creq.valid), 32'd0);

    // Reset asserted during beat 5 of an 8-beat burst
    tick();
    set_req(0, 1'b1, 32'h0000_6000, LEN8);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_resp(1'b1, 1'b0, 32'h600 + 32'(b));
      tick();
    end
    set_resp(1'b1, 1'b0, 32'h604);
    #1 check("t5_beat5_routed", oresps[0].data, 32'h604);
    reset_ = 1'b0;
    #1 check("t5_rst_creq_valid", 32'(creq.valid), 32'd0);
    check("t5_rst_oresp0_zero", 32'(oresps[0] != '0), 32'd0);
    check("t5_rst_oresp1_zero", 32'(oresps[1] != '0), 32'd0);
    set_req(0, 1'b0, 32'h0000_6000, LEN8);
    set_resp(1'b0, 1'b0, 32'h0);
    #2 reset_ = 1'b1;
    tick();
    set_req(1, 1'b1, 32'h0000_7000, LEN1);
    #1 check("t5_post_sel_cycle", 32'(creq.valid), 32'd0);
    tick();
    #1 check("t5_post_grant", 32'(creq.valid), 32'd1);
    check("t5_post_addr", creq.addr, 32'h0000_7000);
    set_resp(1'b1, 1'b1, 32'h7777_7777);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0000_7000, LEN1);
    #1 check("t5_post_idle", 32'(creq.valid), 32'd0);

    // Memory stalls 10 cycles mid-burst while port 1 waits
    tick();
    set_req(0, 1'b1, 32'h0000_9000, LEN4);
    tick();
    set_resp(1'b1, 1'b0, 32'h900);
    #1 check("t6_beat0", oresps[0].data, 32'h900);
    tick();
    for (int s = 0; s < 10; s++) begin
      set_resp(1'b0, 1'b0, 32'h0);
      set_req(1, 1'b1, 32'h0000_A000, LEN1);
      #1 check("t6_stall_addr", creq.addr, 32'h0000_9000);
      check("t6_stall_len", 32'(creq.len), 32'(LEN4));
      check("t6_stall_p1_zero", 32'(oresps[1] != '0), 32'd0);
      tick();
    end
    for (int b = 1; b < 4; b++) begin
      set_resp(1'b1, b == 3, 32'h900 + 32'(b));
      #1 check("t6_beat_data", oresps[0].data, 32'h900 + 32'(b));
      tick();
    end
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(0, 1'b0, 32'h0000_9000, LEN4);
    #1 check("t6_bubble", 32'(creq.valid), 32'd0);
    tick();
    #1 check("t6_p1_granted", creq.addr, 32'h0000_A000);
    check("t6_p1_valid", 32'(creq.valid), 32'd1);
    set_resp(1'b1, 1'b1, 32'hAAAA_0000);
    #1 check("t6_p1_resp", oresps[1].data, 32'hAAAA_0000);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0000_A000, LEN1);
    #1 check("t6_final_idle", 32'(creq.valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
